// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream input and instruction-memory write port of the program loader
//   in_valid/in_data/in_ready : framed byte stream, valid/ready handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port (byte address, word aligned)
//   master = stream source and memory side, slave = loader
interface inst_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: loads a framed, checksummed byte stream into instruction memory as big-endian words
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : arms a new load when idle, done or in error
//   bus            : byte stream in, memory write port out
//   cpu_hold_o     : stalls fetch while a frame is in progress
//   done_o/error_o : load finished with good checksum / overflow or bad checksum
//   words_loaded_o : words written in the current or last load
module inst_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  inst_loader_if.slave      bus,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-2:0] words_loaded_o
);
  localparam logic [2:0] IDLE = 3'd0, HDR_HI = 3'd1, HDR_LO = 3'd2, DATA = 3'd3,
                         CSUM = 3'd4, DONE = 3'd5, ERROR = 3'd6;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  logic [2:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-2:0] n_q, n_d;
  logic [ADDR_W-2:0] wcnt_q, wcnt_d;
  logic [ADDR_W-2:0] words_q, words_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       acc_q, acc_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy, hs, go;
  logic [15:0]       n_in;
  logic [7:0]        din;
  assign busy           = state_q >= HDR_HI && state_q <= CSUM;
  assign hs             = bus.in_valid && busy;
  assign go             = start_i && !busy;
  assign din            = bus.in_data;
  assign n_in           = {hi_q, din};
  assign bus.in_ready   = busy;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign cpu_hold_o     = busy;
  assign done_o         = state_q == DONE;
  assign error_o        = state_q == ERROR;
  assign words_loaded_o = words_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q + {{(ADDR_W-2){1'b0}}, we_q};
    if (go) begin
      state_d = HDR_HI;
      n_d     = '0;
      wcnt_d  = '0;
      lane_d  = '0;
      sum_d   = '0;
      words_d = '0;
    end else if (hs) begin
      case (state_q)
        HDR_HI: begin
          hi_d    = din;
          state_d = HDR_LO;
        end
        HDR_LO: begin
          // an oversized count is rejected before any payload is taken
          n_d     = n_in[ADDR_W-2:0];
          state_d = n_in == '0 ? CSUM : n_in > DEPTH_W ? ERROR : DATA;
        end
        DATA: begin
          sum_d  = sum_q + din;
          lane_d = lane_q + 1'b1;
          acc_d  = {acc_q[15:0], din};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {wcnt_q[ADDR_W-3:0], 2'b00};
            wdata_d = {acc_q, din};
            wcnt_d  = wcnt_q + 1'b1;
            state_d = wcnt_q + 1'b1 == n_q ? CSUM : DATA;
          end
        end
        CSUM: state_d = din == sum_q ? DONE : ERROR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      words_q <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      words_q <= words_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold, done, error;
  logic [8:0] words;
  int         n_chk = 0;
  int         n_pass = 0;
  int         wr_n = 0;
  int         base;
  logic [9:0]  la [512];
  logic [31:0] ld [512];
  logic [31:0] pay [256];
  inst_loader_if #(.ADDR_W(10)) bus ();
  inst_loader #(.DEPTH(256), .ADDR_W(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .bus           (bus),
    .cpu_hold_o    (hold),
    .done_o        (done),
    .error_o       (error),
    .words_loaded_o(words)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_we) begin
      la[wr_n] <= bus.mem_addr;
      ld[wr_n] <= bus.mem_wdata;
      wr_n     <= wr_n + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic send(input logic [7:0] b, input logic w4, input bit bub);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk("we_after_byte", {31'd0, bus.mem_we}, {31'd0, w4});
    if (bub) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("we_bubble", {31'd0, bus.mem_we}, 32'd0);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic frame(input logic [15:0] n, input int nw, input logic [7:0] cs,
                       input bit bub, input bit mid_start, input bit do_cs);
    pulse_start();
    chk("start_hold", {31'd0, hold}, 32'd1);
    chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_words", {23'd0, words}, 32'd0);
    send(n[15:8], 1'b0, bub);
    send(n[7:0], 1'b0, bub);
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < 4; b++) begin
        if (mid_start && w == 0 && b == 2) start = 1'b1;
        send(pay[w][31-8*b -: 8], b == 3, bub);
        start = 1'b0;
      end
    if (do_cs) send(cs, 1'b0, bub);
    bus.in_valid = 1'b0;
  endtask
  task automatic chk_end(input string tag, input logic d, input logic e, input int nwr, input int nwords);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_hold"}, {31'd0, hold}, 32'd0);
    chk({tag, "_writes"}, wr_n - base, nwr);
    chk({tag, "_words"}, {23'd0, words}, nwords);
  endtask
  task automatic chk_two(input string tag);
    chk({tag, "_addr0"}, {22'd0, la[base]}, 32'h0);
    chk({tag, "_data0"}, ld[base], 32'h20080005);
    chk({tag, "_addr1"}, {22'd0, la[base+1]}, 32'h4);
    chk({tag, "_data1"}, ld[base+1], 32'h8C090000);
  endtask
  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    pay[0] = 32'h20080005;
    pay[1] = 32'h8C090000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_words", {23'd0, words}, 32'd0);
    chk("rst_writes", wr_n, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    // 20+08+00+05+8C+09+00+00 = C2 mod 256
    base = wr_n;
    frame(16'd2, 2, 8'hC2, 1'b0, 1'b0, 1'b1);
    chk_end("two", 1'b1, 1'b0, 2, 2);
    chk_two("two");
    base = wr_n;
    frame(16'd2, 2, 8'hC2, 1'b1, 1'b0, 1'b1);
    chk_end("bubbly", 1'b1, 1'b0, 2, 2);
    chk_two("bubbly");
    base = wr_n;
    frame(16'd2, 2, 8'hBB, 1'b0, 1'b0, 1'b1);
    chk_end("badsum", 1'b0, 1'b1, 2, 2);
    chk_two("badsum");
    base = wr_n;
    frame(16'd0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_end("zero", 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 256; i++) pay[i] = i;
    base = wr_n;
    frame(16'd256, 256, 8'h80, 1'b0, 1'b0, 1'b1);
    chk_end("full", 1'b1, 1'b0, 256, 256);
    chk("full_last_addr", {22'd0, la[base+255]}, 32'h3FC);
    chk("full_last_data", ld[base+255], 32'h000000FF);
    chk("full_mid_data", ld[base+100], 32'd100);
    base = wr_n;
    frame(16'd257, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_end("over", 1'b0, 1'b1, 0, 0);
    chk("over_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("over_ready_held", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    pay[0] = 32'h20080005;
    pay[1] = 32'h8C090000;
    base = wr_n;
    frame(16'd2, 2, 8'hC2, 1'b0, 1'b1, 1'b1);
    chk_end("busy_start", 1'b1, 1'b0, 2, 2);
    chk_two("busy_start");
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_words", {23'd0, words}, 32'd0);
    chk("restart_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("restart_hold", {31'd0, hold}, 32'd1);
    send(8'h00, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    for (int b = 0; b < 5; b++) send(pay[b/4][31-8*(b%4) -: 8], b == 3, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hold", {31'd0, hold}, 32'd0);
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_words", {23'd0, words}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_hold", {31'd0, hold}, 32'd0);
    chk("midrst_idle_done", {31'd0, done}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
